adc_mux_arbiter: RTL and testbench
==================================

ADC_MUX_ARBITER -- requirements
Module: adc_mux_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 10: ADC sample width.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 24: cycles discarded after any mux change (analog settle plus ADC pipeline); legal range 1..255.
REQ-003 SHALL have parameter RELEASE_HOLD, default 48: cycles the OCD keeps ownership after ocd_req drops; legal range 1..255.
REQ-004 SHALL have port clk, input, 1: the 240 MHz datapath clock; all logic on its rising edge.
REQ-005 SHALL have port resetn, input, 1: one clock; reset is synchronous and active-low.
REQ-006 SHALL have port ocd_req, input, 1: QCW over-current detector requests the shared ADC (high for the burst).
REQ-007 SHALL have port boost_req, input, 1: boost controller wants inductor-current samples.
REQ-008 SHALL have port adc_data, input, DATA_W: shared ADC sample.
REQ-009 SHALL have port adc_mux, output, 1: 1 = OCD current sense, 0 = boost current sense; registered.
REQ-010 SHALL have port ocd_ready, output, 1: mux settled on OCD; QCW start is permitted only while high.
REQ-011 SHALL have ports ocd_valid (1) and ocd_data (DATA_W), outputs: OCD sample stream.
REQ-012 SHALL have ports boost_valid (1) and boost_data (DATA_W), outputs: boost sample stream.
REQ-013 SHALL have port boost_hold, output, 1: boost must stop switching; no valid current sense available.
REQ-014 SHALL have port switch_count, output, 16: mux-change counter, saturating.

Function
REQ-015 SHALL implement states S_BOOST, S_SW_OCD, S_OCD, S_HOLD, S_SW_BOOST with a single 8-bit settle/hold down-counter.
REQ-016 SHALL drive adc_mux = 1 in S_SW_OCD, S_OCD and S_HOLD, and 0 otherwise.
REQ-017 S_BOOST: ocd_req=1 -> S_SW_OCD with the counter loaded for SETTLE_CYCLES.
REQ-018 S_SW_OCD SHALL last exactly SETTLE_CYCLES cycles, then -> S_OCD; ocd_req dropping during settle SHALL NOT abort it (-> S_OCD, then the normal hold applies).
REQ-019 S_OCD: ocd_req=0 -> S_HOLD with the counter loaded for RELEASE_HOLD.
REQ-020 S_HOLD: ocd_req=1 -> S_OCD on the next cycle; otherwise after exactly RELEASE_HOLD cycles -> S_SW_BOOST with the counter loaded for SETTLE_CYCLES.
REQ-021 S_SW_BOOST: ocd_req=1 preempts -> S_SW_OCD with the counter reloaded; otherwise after exactly SETTLE_CYCLES cycles -> S_BOOST.
REQ-022 OCD SHALL have strict priority; boost_req SHALL never affect state transitions.
REQ-023 ocd_ready SHALL be high exactly in S_OCD and S_HOLD.
REQ-024 boost_hold SHALL be high in every state except S_BOOST.
REQ-025 ocd_valid(t+1) SHALL equal ocd_ready(t), and ocd_data(t+1) SHALL equal adc_data(t) (1-cycle latency); ocd_data SHALL hold its value when not valid.
REQ-026 boost_valid(t+1) SHALL equal (state(t)==S_BOOST AND boost_req(t)), and boost_data(t+1) SHALL equal adc_data(t); boost_data SHALL hold its value when not valid.
REQ-027 ocd_valid and boost_valid SHALL never be high in the same cycle.
REQ-028 switch_count SHALL increment by 1 on every cycle in which adc_mux changes value, and SHALL saturate at 0xFFFF.

Reset
REQ-029 resetn=0 sampled at a clock edge SHALL force state S_SW_BOOST with the counter loaded for SETTLE_CYCLES, adc_mux=0, ocd_ready=0, ocd_valid=0, boost_valid=0, ocd_data=0, boost_data=0, boost_hold=1 and switch_count=0.
REQ-030 Reset asserted mid-burst SHALL take effect on the next edge regardless of ocd_req; after release the block SHALL settle SETTLE_CYCLES cycles before entering S_BOOST or, if ocd_req=1, preempt to S_SW_OCD.

Verification
REQ-031 Reset release, ocd_req=0, boost_req=1 -> boost_hold falls after 24 cycles; first boost_valid 1 cycle later; adc_data=0x155 appears on boost_data 1 cycle later.
REQ-032 In S_BOOST pulse ocd_req=1 -> next cycle adc_mux=1, switch_count=1, boost_hold=1; ocd_ready rises after 24 cycles; ocd_valid follows 1 cycle later.
REQ-033 ocd_req drops, then re-asserts 10 cycles later -> adc_mux stays 1, ocd_ready never falls, switch_count unchanged.
REQ-034 ocd_req drops and stays low -> ocd_ready falls after 48 cycles; adc_mux=0; 24 cycles later boost_hold=0; switch_count=2.
REQ-035 ocd_req=1 during cycle 12 of S_SW_BOOST -> adc_mux returns to 1, a full 24-cycle settle restarts, and no boost_valid is emitted.
REQ-036 Assert resetn=0 while in S_OCD -> next cycle all outputs at REQ-029 values; force switch_count to 0xFFFF via toggling -> further toggles leave it at 0xFFFF.

Source files
------------

// File: rtl/adc_mux_arbiter.sv
// adc_mux_arbiter
//   Shares one ADC between the QCW over-current detector (OCD) and the boost
//   converter current loop. The OCD has strict priority. Every mux change is
//   followed by a settle window whose samples are discarded. After the OCD
//   releases its request, ownership is kept for a hold window so that a
//   quickly re-asserted burst finds the mux already settled.
//
// Parameters
//   DATA_W        ADC sample width
//   SETTLE_CYCLES cycles discarded after a mux change (1..255)
//   RELEASE_HOLD  cycles the OCD keeps ownership after ocd_req drops (1..255)
//
// Ports
//   clk          240 MHz datapath clock, rising edge
//   resetn       synchronous, active-low reset
//   ocd_req      OCD requests the ADC (high for the burst)
//   boost_req    boost controller wants a current sample
//   adc_data     shared ADC sample
//   adc_mux      registered mux select: 1 = OCD sense, 0 = boost sense
//   ocd_ready    mux settled on OCD; QCW start permitted only while high
//   ocd_valid    OCD sample strobe, ocd_data holds between strobes
//   ocd_data     OCD sample
//   boost_valid  boost sample strobe, boost_data holds between strobes
//   boost_data   boost sample
//   boost_hold   boost must stop switching (no valid current sense)
//   switch_count saturating count of mux changes
module adc_mux_arbiter #(
  parameter int DATA_W        = 10,
  parameter int SETTLE_CYCLES = 24,
  parameter int RELEASE_HOLD  = 48
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ocd_req,
  input  logic              boost_req,
  input  logic [DATA_W-1:0] adc_data,
  output logic              adc_mux,
  output logic              ocd_ready,
  output logic              ocd_valid,
  output logic [DATA_W-1:0] ocd_data,
  output logic              boost_valid,
  output logic [DATA_W-1:0] boost_data,
  output logic              boost_hold,
  output logic [15:0]       switch_count
);

  // The counter is loaded with N-1 and the state exits when it reads zero,
  // so the state occupies exactly N cycles.
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] HOLD_LOAD   = 8'(RELEASE_HOLD - 1);

  typedef enum logic [2:0] {
    S_BOOST,
    S_SW_OCD,
    S_OCD,
    S_HOLD,
    S_SW_BOOST
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  cnt;
  logic [7:0]  cnt_nxt;
  logic        mux_nxt;
  logic        boost_take;
  logic [15:0] count_nxt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_SW_BOOST;
      cnt   <= SETTLE_LOAD;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and state-decoded outputs. boost_req is deliberately absent:
  // it never influences ownership.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    ocd_ready  = 1'b0;
    boost_hold = 1'b1;
    boost_take = 1'b0;
    case (state)
      S_BOOST: begin
        boost_hold = 1'b0;
        boost_take = boost_req;
        if (ocd_req) begin
          state_nxt = S_SW_OCD;
          cnt_nxt   = SETTLE_LOAD;
        end
      end
      S_SW_OCD: begin
        // A dropped request does not abort the settle; S_OCD then hands
        // off to the normal hold.
        if (cnt == 8'd0) state_nxt = S_OCD;
        else             cnt_nxt   = cnt - 8'd1;
      end
      S_OCD: begin
        ocd_ready = 1'b1;
        if (!ocd_req) begin
          state_nxt = S_HOLD;
          cnt_nxt   = HOLD_LOAD;
        end
      end
      S_HOLD: begin
        ocd_ready = 1'b1;
        if (ocd_req) begin
          state_nxt = S_OCD;
        end else if (cnt == 8'd0) begin
          state_nxt = S_SW_BOOST;
          cnt_nxt   = SETTLE_LOAD;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      S_SW_BOOST: begin
        if (ocd_req) begin
          state_nxt = S_SW_OCD;
          cnt_nxt   = SETTLE_LOAD;
        end else if (cnt == 8'd0) begin
          state_nxt = S_BOOST;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      default: begin
        state_nxt = S_SW_BOOST;
        cnt_nxt   = SETTLE_LOAD;
      end
    endcase
  end

  // adc_mux is registered from the next state so it lines up with state.
  assign mux_nxt = (state_nxt == S_SW_OCD) || (state_nxt == S_OCD) ||
                   (state_nxt == S_HOLD);

  always_comb begin
    count_nxt = switch_count;
    if (mux_nxt != adc_mux) count_nxt = sat_inc16(switch_count);
  end

  // Output stage: samples captured with one cycle of latency.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      adc_mux      <= 1'b0;
      switch_count <= 16'd0;
      ocd_valid    <= 1'b0;
      boost_valid  <= 1'b0;
      ocd_data     <= '0;
      boost_data   <= '0;
    end else begin
      adc_mux      <= mux_nxt;
      switch_count <= count_nxt;
      ocd_valid    <= ocd_ready;
      boost_valid  <= boost_take;
      if (ocd_ready)  ocd_data   <= adc_data;
      if (boost_take) boost_data <= adc_data;
    end
  end

endmodule

// File: tb/tb_adc_mux_arbiter.sv
// tb_adc_mux_arbiter
//   Directed bench for adc_mux_arbiter with default parameters. Each step
//   drives one cycle of inputs and pushes the expected sample-stream result
//   into a scoreboard; a monitor pops one entry per clock and compares the
//   valid strobes and data (including hold-when-not-valid). State-level
//   outputs are compared inline in the directed sequence.
module tb_adc_mux_arbiter;

  localparam int DW = 10;

  logic          clk;
  logic          resetn;
  logic          ocd_req;
  logic          boost_req;
  logic [DW-1:0] adc_data;
  logic          adc_mux;
  logic          ocd_ready;
  logic          ocd_valid;
  logic [DW-1:0] ocd_data;
  logic          boost_valid;
  logic [DW-1:0] boost_data;
  logic          boost_hold;
  logic [15:0]   switch_count;

  adc_mux_arbiter #(
    .DATA_W(DW),
    .SETTLE_CYCLES(24),
    .RELEASE_HOLD(48)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .ocd_req(ocd_req),
    .boost_req(boost_req),
    .adc_data(adc_data),
    .adc_mux(adc_mux),
    .ocd_ready(ocd_ready),
    .ocd_valid(ocd_valid),
    .ocd_data(ocd_data),
    .boost_valid(boost_valid),
    .boost_data(boost_data),
    .boost_hold(boost_hold),
    .switch_count(switch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          ov;
    logic          bv;
    logic [DW-1:0] d;
  } exp_t;

  exp_t          q[$];
  int            nchk = 0;
  int            nerr = 0;
  logic [DW-1:0] last_o;
  logic [DW-1:0] last_b;

  task automatic check1(input string tag, input logic obs, input logic exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic checkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: one entry per driven cycle, compared after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.rst) begin
        last_o = '0;
        last_b = '0;
      end
      check1("ocd_valid", ocd_valid, e.ov);
      check1("boost_valid", boost_valid, e.bv);
      check1("valid_exclusive", ocd_valid & boost_valid, 1'b0);
      if (e.ov) last_o = e.d;
      if (e.bv) last_b = e.d;
      checkd("ocd_data", ocd_data, last_o);
      checkd("boost_data", boost_data, last_b);
    end
  end

  // eo/eb: the sample driven this cycle must appear on the OCD/boost stream.
  task automatic step(input logic rn, input logic o, input logic b,
                      input logic eo, input logic eb, input logic [DW-1:0] a);
    exp_t e;
    @(negedge clk);
    resetn    = rn;
    ocd_req   = o;
    boost_req = b;
    adc_data  = a;
    e.rst = ~rn;
    e.ov  = rn & eo;
    e.bv  = rn & eb;
    e.d   = a;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int n, input logic rn, input logic o, input logic b,
                     input logic eo, input logic eb);
    for (int i = 0; i < n; i++) step(rn, o, b, eo, eb, DW'($urandom));
  endtask

  task automatic check_reset(input string tag);
    check1({tag, "_adc_mux"}, adc_mux, 1'b0);
    check1({tag, "_ocd_ready"}, ocd_ready, 1'b0);
    check1({tag, "_ocd_valid"}, ocd_valid, 1'b0);
    check1({tag, "_boost_valid"}, boost_valid, 1'b0);
    checkd({tag, "_ocd_data"}, ocd_data, '0);
    checkd({tag, "_boost_data"}, boost_data, '0);
    check1({tag, "_boost_hold"}, boost_hold, 1'b1);
    check16({tag, "_switch_count"}, switch_count, 16'd0);
  endtask

  initial begin
    resetn    = 1'b0;
    ocd_req   = 1'b0;
    boost_req = 1'b0;
    adc_data  = '0;

    // Reset, then release into the 24-cycle settle toward boost
    run(2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_reset("rst0");
    run(23, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check1("release_hold_23", boost_hold, 1'b1);
    run(1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check1("release_hold_24", boost_hold, 1'b0);
    check1("release_mux", adc_mux, 1'b0);

    // First boost sample
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 10'h155);
    check1("boost_first_valid", boost_valid, 1'b1);
    checkd("boost_first_data", boost_data, 10'h155);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, DW'($urandom));
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, DW'($urandom));

    // OCD request from S_BOOST
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, DW'($urandom));
    check1("ocd_req_mux", adc_mux, 1'b1);
    check16("ocd_req_count", switch_count, 16'd1);
    check1("ocd_req_hold", boost_hold, 1'b1);
    check1("ocd_req_ready", ocd_ready, 1'b0);
    run(23, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check1("settle_23_ready", ocd_ready, 1'b0);
    run(1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check1("settle_24_ready", ocd_ready, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, DW'($urandom));
    check1("ocd_first_valid", ocd_valid, 1'b1);
    run(2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    // Drop, re-assert 10 cycles later: ownership kept
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, DW'($urandom));
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, DW'($urandom));
      check1("reassert_ready", ocd_ready, 1'b1);
      check1("reassert_mux", adc_mux, 1'b1);
    end
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, DW'($urandom));
    check1("reassert_ready_end", ocd_ready, 1'b1);
    check16("reassert_count", switch_count, 16'd1);
    run(2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    // Drop and stay low: 48-cycle hold, then 24-cycle settle
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, DW'($urandom));
    run(47, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check1("hold_47_ready", ocd_ready, 1'b1);
    run(1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check1("hold_48_ready", ocd_ready, 1'b0);
    check1("hold_48_mux", adc_mux, 1'b0);
    check16("hold_48_count", switch_count, 16'd2);
    run(23, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check1("swb_23_hold", boost_hold, 1'b1);
    run(1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check1("swb_24_hold", boost_hold, 1'b0);

    // Settle not aborted by a dropped request
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, DW'($urandom));
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, DW'($urandom));
    check16("second_req_count", switch_count, 16'd3);
    run(4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    run(19, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check1("noabort_23_ready", ocd_ready, 1'b0);
    run(1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check1("noabort_24_ready", ocd_ready, 1'b1);
    check1("noabort_mux", adc_mux, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, DW'($urandom));
    run(48, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check1("noabort_release_mux", adc_mux, 1'b0);
    check16("noabort_release_count", switch_count, 16'd4);

    // Preempt during cycle 12 of S_SW_BOOST
    run(11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check1("preempt_pre_mux", adc_mux, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, DW'($urandom));
    check1("preempt_mux", adc_mux, 1'b1);
    check16("preempt_count", switch_count, 16'd5);
    check1("preempt_ready", ocd_ready, 1'b0);
    run(23, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check1("preempt_23_ready", ocd_ready, 1'b0);
    run(1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check1("preempt_24_ready", ocd_ready, 1'b1);
    run(2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    // Reset while in S_OCD with ocd_req high
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, DW'($urandom));
    check_reset("rst_ocd");

    // Saturation: preload the counter path near the top, then toggle
    force dut.count_nxt = 16'hFFFD;
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, DW'($urandom));
    release dut.count_nxt;
    check16("sat_preload", switch_count, 16'hFFFD);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, DW'($urandom));
    check16("sat_fffe", switch_count, 16'hFFFE);
    run(24, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check1("sat_ready", ocd_ready, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, DW'($urandom));
    run(48, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check1("sat_ffff_mux", adc_mux, 1'b0);
    check16("sat_ffff", switch_count, 16'hFFFF);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, DW'($urandom));
    check1("sat_hold_mux", adc_mux, 1'b1);
    check16("sat_hold_1", switch_count, 16'hFFFF);
    run(24, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, DW'($urandom));
    run(48, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check1("sat_hold_mux2", adc_mux, 1'b0);
    check16("sat_hold_2", switch_count, 16'hFFFF);

    check1("scoreboard_empty", q.size() == 0, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
